// File: rtl/dct_pkg.sv
// Shared definitions for the 8-point 1-D DCT sequencing controller:
// FSM state encoding, transform size and index width.
package dct_pkg;

   localparam int DCT_PTS   = 8;
   localparam int DCT_IDX_W = 3;
   localparam int DCT_N     = 16;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOAD   = 2'd1,
      ST_SETTLE = 2'd2,
      ST_DRAIN  = 2'd3
   } dct_state_e;

   function automatic logic is_last(input logic [DCT_IDX_W-1:0] idx);
      return idx == DCT_IDX_W'(DCT_PTS - 1);
   endfunction

endpackage

// File: rtl/dct1d_seq_obuf.sv
// One-entry registered valid/ready output stage holding {data, idx, last}.
// Contents hold stable while valid is high and the consumer stalls.
module dct1d_seq_obuf
   import dct_pkg::*;
#(
   parameter int N = DCT_N
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_clr,
   input  logic                 i_load,
   input  logic [N-1:0]         i_data,
   input  logic [DCT_IDX_W-1:0] i_idx,
   input  logic                 i_ready,
   output logic                 o_valid,
   output logic [N-1:0]         o_data,
   output logic [DCT_IDX_W-1:0] o_idx,
   output logic                 o_last
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         o_valid <= 1'b0;
         o_data  <= '0;
         o_idx   <= '0;
         o_last  <= 1'b0;
      end else if (i_clr) begin
         o_valid <= 1'b0;
      end else if (i_load) begin
         o_valid <= 1'b1;
         o_data  <= i_data;
         o_idx   <= i_idx;
         o_last  <= is_last(i_idx);
      end else if (i_ready) begin
         // Beat consumed with nothing new to replace it.
         o_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/dct1d_seq.sv
// Sequencer for the 8-point 1-D DCT engine: loads 8 samples, waits for the
// combinational tree to settle, drains 8 coefficients. Optional block counter
// enabled by DCT1D_SEQ_BLKCNT_EN.
module dct1d_seq
   import dct_pkg::*;
#(
   parameter int N          = DCT_N,
   parameter int SETTLE_CYC = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 abort,
   input  logic                 s_valid,
   output logic                 s_ready,
   input  logic [N-1:0]         s_data,
   output logic                 eng_wr,
   output logic [DCT_IDX_W-1:0] eng_add,
   output logic [N-1:0]         eng_data,
   output logic                 eng_oe,
   output logic [DCT_IDX_W-1:0] eng_sel,
   input  logic [N-1:0]         eng_coef,
   output logic                 m_valid,
   input  logic                 m_ready,
   output logic [N-1:0]         m_data,
   output logic [DCT_IDX_W-1:0] m_idx,
   output logic                 m_last,
   output logic                 busy
`ifdef DCT1D_SEQ_BLKCNT_EN
   ,
   output logic [15:0]          blk_cnt
`endif
);

   localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC - 1);

   dct_state_e r_state;
   logic [3:0] r_wr_cnt;
   logic [3:0] r_settle_cnt;
   logic [3:0] r_rd_idx;

   logic w_wr;
   logic w_take;
   logic w_done;

   assign s_ready  = ((r_state == ST_IDLE) || (r_state == ST_LOAD)) && !abort;
   assign w_wr     = s_valid && s_ready;
   assign eng_wr   = w_wr;
   assign eng_add  = r_wr_cnt[2:0];
   assign eng_data = w_wr ? s_data : '0;
   assign eng_oe   = (r_state == ST_DRAIN);
   assign eng_sel  = r_rd_idx[2:0];
   assign busy     = (r_state != ST_IDLE);

   // rd_idx==8 means all eight coefficients have been issued to the output stage.
   assign w_take = eng_oe && !r_rd_idx[3] && (!m_valid || m_ready);
   assign w_done = eng_oe &&  r_rd_idx[3] && m_valid && m_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= ST_IDLE;
         r_wr_cnt     <= '0;
         r_settle_cnt <= '0;
         r_rd_idx     <= '0;
      end else if (abort) begin
         r_state      <= ST_IDLE;
         r_wr_cnt     <= '0;
         r_settle_cnt <= '0;
         r_rd_idx     <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_wr) begin
                  r_state  <= ST_LOAD;
                  r_wr_cnt <= 4'd1;
               end
            end
            ST_LOAD: begin
               if (w_wr) begin
                  r_wr_cnt <= r_wr_cnt + 4'd1;
                  if (r_wr_cnt == 4'd7) begin
                     r_state      <= ST_SETTLE;
                     r_settle_cnt <= '0;
                  end
               end
            end
            ST_SETTLE: begin
               if (r_settle_cnt == SETTLE_LAST) begin
                  r_state  <= ST_DRAIN;
                  r_rd_idx <= '0;
               end else begin
                  r_settle_cnt <= r_settle_cnt + 4'd1;
               end
            end
            ST_DRAIN: begin
               if (w_take) r_rd_idx <= r_rd_idx + 4'd1;
               if (w_done) begin
                  r_state  <= ST_IDLE;
                  r_wr_cnt <= '0;
                  r_rd_idx <= '0;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   dct1d_seq_obuf #(.N(N)) u_obuf (
      .clk     (clk),
      .rst     (reset),
      .i_clr   (abort),
      .i_load  (w_take && !abort),
      .i_data  (eng_coef),
      .i_idx   (r_rd_idx[2:0]),
      .i_ready (m_ready),
      .o_valid (m_valid),
      .o_data  (m_data),
      .o_idx   (m_idx),
      .o_last  (m_last)
   );

`ifdef DCT1D_SEQ_BLKCNT_EN
   // Survives abort on purpose: counts only completed blocks since reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                blk_cnt <= '0;
      else if (w_done && !abort) blk_cnt <= blk_cnt + 16'd1;
   end
`endif

endmodule

// File: tb/tb_dct1d_seq.sv
// Self-checking bench for dct1d_seq: random samples and coefficient tables,
// engine memory model, backpressure, input gaps, abort and async reset.
module tb_dct1d_seq;

   localparam int N          = 16;
   localparam int SETTLE_CYC = 2;

   logic          clk = 1'b0;
   logic          reset, abort, s_valid, s_ready, eng_wr, eng_oe;
   logic [N-1:0]  s_data, eng_data, eng_coef, m_data;
   logic [2:0]    eng_add, eng_sel, m_idx;
   logic          m_valid, m_ready, m_last, busy;
`ifdef DCT1D_SEQ_BLKCNT_EN
   logic [15:0]   blk_cnt;
`endif

   logic [N-1:0]  coef_tbl [8];
   logic [N-1:0]  smp [8];
   logic [18:0]   wr_q [$];
   int            n_cmp = 0;
   int            n_err = 0;
   int            exp_blk = 0;

   always #5 clk = ~clk;

   // Engine model: combinational coefficient lookup, only meaningful with oe.
   assign eng_coef = eng_oe ? coef_tbl[eng_sel] : 16'hDEAD;

   always @(negedge clk) if (eng_wr) wr_q.push_back({eng_add, eng_data});

   dct1d_seq #(.N(N), .SETTLE_CYC(SETTLE_CYC)) dut (
      .clk(clk), .reset(reset), .abort(abort),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .eng_wr(eng_wr), .eng_add(eng_add), .eng_data(eng_data),
      .eng_oe(eng_oe), .eng_sel(eng_sel), .eng_coef(eng_coef),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
      .m_idx(m_idx), .m_last(m_last), .busy(busy)
`ifdef DCT1D_SEQ_BLKCNT_EN
      , .blk_cnt(blk_cnt)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic new_tables(input bit basic);
      for (int i = 0; i < 8; i++) begin
         smp[i]      = basic ? 16'(i + 1)  : 16'($urandom);
         coef_tbl[i] = basic ? 16'(i * 10) : 16'($urandom);
      end
   endtask

   // Offers samples smp[0..cnt-1]; with gaps, s_valid alternates 1/0.
   task automatic feed(input bit gaps, input int cnt);
      int  k = 0;
      int  g = 0;
      bit  hs;
      while (k < cnt && g < 64) begin
         s_valid = gaps ? ((g % 2) == 0) : 1'b1;
         s_data  = s_valid ? smp[k] : 16'($urandom);
         #1;
         chk("s_ready_load", s_ready, 1);
         hs = s_valid && s_ready;
         tick();
         if (hs) k++;
         g++;
      end
      chk("feed_done", k, cnt);
   endtask

   task automatic wait_first(input int exp_lat);
      int n = 0;
      while (!m_valid && n < 20) begin
         chk("s_ready_settle", s_ready, 0);
         tick();
         n++;
      end
      chk("latency", n, exp_lat);
   endtask

   task automatic run_block(input bit basic, input bit gaps, input int bp_at, input int bp_len);
      int b = 0;
      int st = 0;
      int g = 0;
      new_tables(basic);
      wr_q.delete();
      m_ready = 1'b1;
      feed(gaps, 8);
      // With gaps, keep offering junk samples that must be ignored.
      s_valid = gaps;
      wait_first(SETTLE_CYC + 1);
      while (b < 8 && g < 64) begin
         m_ready = !(b == bp_at && st < bp_len);
         s_data  = 16'($urandom);
         #1;
         chk("m_valid", m_valid, 1);
         chk("m_data", m_data, coef_tbl[b]);
         chk("m_idx", m_idx, b[2:0]);
         chk("m_last", m_last, (b == 7));
         chk("eng_oe", eng_oe, 1);
         chk("s_ready_drain", s_ready, 0);
         chk("eng_wr_drain", eng_wr, 0);
         tick();
         if (m_ready) b++; else st++;
         g++;
      end
      m_ready = 1'b1;
      s_valid = 1'b0;
      #1;
      chk("busy_end", busy, 0);
      chk("m_valid_end", m_valid, 0);
      chk("s_ready_idle", s_ready, 1);
      chk("wr_count", wr_q.size(), 8);
      for (int i = 0; i < 8 && i < wr_q.size(); i++) begin
         chk("wr_add", wr_q[i][18:16], i);
         chk("wr_data", wr_q[i][15:0], smp[i]);
      end
      exp_blk++;
`ifdef DCT1D_SEQ_BLKCNT_EN
      chk("blk_cnt", blk_cnt, exp_blk);
`endif
   endtask

   task automatic abort_in_drain();
      new_tables(1'b0);
      m_ready = 1'b1;
      feed(1'b0, 8);
      s_valid = 1'b0;
      wait_first(SETTLE_CYC + 1);
      tick();
      tick();
      chk("abort_drain_idx", m_idx, 2);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      #1;
      chk("abort_drain_mvalid", m_valid, 0);
      chk("abort_drain_busy", busy, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; abort = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b1;
      for (int i = 0; i < 8; i++) coef_tbl[i] = '0;
      #3;
      chk("rst_s_ready", s_ready, 1);
      chk("rst_m_valid", m_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_eng_wr", eng_wr, 0);
      chk("rst_eng_oe", eng_oe, 0);
      chk("rst_m_last", m_last, 0);
      #20 reset = 1'b0;
      tick();

      // Basic block, then backpressure at idx 3, then gapped input.
      run_block(1'b1, 1'b0, -1, 0);
      run_block(1'b0, 1'b0, 3, 5);
      run_block(1'b0, 1'b1, -1, 0);

      // Abort while loading, at wr_cnt=5 with a sample offered.
      new_tables(1'b0);
      wr_q.delete();
      feed(1'b0, 5);
      s_valid = 1'b1;
      s_data  = smp[5];
      abort   = 1'b1;
      #1;
      chk("abort_s_ready", s_ready, 0);
      chk("abort_eng_wr", eng_wr, 0);
      tick();
      abort   = 1'b0;
      s_valid = 1'b0;
      #1;
      chk("abort_load_busy", busy, 0);
      chk("abort_load_writes", wr_q.size(), 5);
      run_block(1'b0, 1'b0, -1, 0);

      abort_in_drain();
      run_block(1'b0, 1'b0, 6, 2);

      // Async reset between clock edges during DRAIN.
      new_tables(1'b0);
      feed(1'b0, 8);
      s_valid = 1'b0;
      wait_first(SETTLE_CYC + 1);
      tick();
      tick();
      #2;
      reset = 1'b1;
      #1;
      chk("areset_m_valid", m_valid, 0);
      chk("areset_s_ready", s_ready, 1);
      chk("areset_busy", busy, 0);
      chk("areset_eng_oe", eng_oe, 0);
      exp_blk = 0;
      #4 reset = 1'b0;
      tick();

      // Three full blocks and one aborted block since reset.
      run_block(1'b1, 1'b0, -1, 0);
      abort_in_drain();
      run_block(1'b0, 1'b0, 0, 3);
      run_block(1'b0, 1'b1, 7, 4);
`ifdef DCT1D_SEQ_BLKCNT_EN
      chk("blk_cnt_final", blk_cnt, 3);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
